trivium_out_buffer: RTL
=======================

# trivium_out_buffer

Ciphertext output buffer sitting directly downstream of the Trivium keystream core. Captures each encrypted byte on the core's one-cycle write strobe, stores it in a FIFO, and presents it to the consumer over a valid/ready byte interface with a batch-end marker. Returns the 2-bit `fifo_cnd` status that the core samples to leave its ready state; the core resumes encryption only on `2'b00`.

## Interface
- `DEPTH`, 256: FIFO capacity in bytes; power of two, ≥ 4.
- `HIWATER`, 192: occupancy at or above which `fifo_cnd` reports high-water; 1 ≤ HIWATER ≤ DEPTH.
- `BURST`, 256: bytes per output batch; drives `m_last`.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous flush; empties buffer, clears overflow and counters.
- `wr_en`  in  1  write strobe from core (`wt_sgn`); one byte per high cycle.
- `wr_data`  in  8  ciphertext byte from core (`stream`).
- `fifo_cnd`  out  2  status to core: 00 empty, 01 non-empty below HIWATER, 10 at/above HIWATER, 11 overflow.
- `m_data`  out  8  output byte.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  consumer accepts byte when `m_valid && m_ready`.
- `m_last`  out  1  qualifies `m_data` as last byte of a BURST.
- `drop_cnt`  out  16  count of dropped bytes, saturating at 16'hFFFF.

## Operation
- Reset values: `fifo_cnd`=00, `m_data`=0, `m_valid`=0, `m_last`=0, `drop_cnt`=0; pointers, occupancy, batch counter, overflow flag = 0.
- Storage: RAM of DEPTH × 8 with synchronous read, plus one output register. Occupancy `occ` (width $clog2(DEPTH)+1) counts bytes in RAM plus output register; range 0..DEPTH.
- Write: `wr_en` with `occ < DEPTH` stores `wr_data`. `wr_en` with `occ == DEPTH` drops the byte, sets sticky overflow, increments `drop_cnt` (saturating). Full check uses `occ` before any same-cycle pop: write at full is dropped even if a pop occurs that cycle.
- Pop: `m_valid && m_ready`. Same-cycle accepted write and pop leave `occ` unchanged.
- Output FSM: EMPTY (no byte in output register) → FETCH (RAM read issued, one cycle) → VALID (`m_valid`=1). In VALID, pop with RAM non-empty → FETCH is skipped: next byte loads back-to-back, `m_valid` stays high (one byte per cycle sustained). Pop with RAM empty → EMPTY. No pop: `m_data`, `m_last` held stable.
- `m_last`: batch counter counts popped bytes modulo BURST; `m_last`=1 while the presented byte's index equals BURST-1. Counter wraps to 0 after that pop.
- `fifo_cnd` priority: overflow → 11; else `occ`=0 → 00; else `occ` ≥ HIWATER → 10; else 01. Registered from next-state values; 11 persists until `clr` or `rst`.
- `clr`: next cycle `occ`=0, pointers 0, FSM EMPTY, `m_valid`=0, overflow cleared, `drop_cnt`=0, batch counter 0. `clr` with `wr_en` same cycle: clr wins; byte discarded, not counted as drop. `clr` with a pop same cycle: pop ignored.
- Pointers: $clog2(DEPTH) bits, natural wrap.

## Timing
- Write to empty buffer at edge N → `m_valid`=1 after edge N+2.
- `fifo_cnd` reflects a write/pop/clr one edge after it is sampled.
- Sustained throughput: one byte/cycle in and out.
- `m_valid` never falls without a pop, `clr`, or `rst`.
- Asynchronous reset mid-transfer: all state to reset values immediately; no byte recovered.

## Structure
- Shared package `trivium_pkg`: enum typedef `fifo_cnd_t` (CND_EMPTY=2'b00, CND_PART=2'b01, CND_HIGH=2'b10, CND_OVF=2'b11) and localparam `TRIV_BURST=256`, reused by the core.
- One sub-module: `trivium_buf_ram`, simple dual-port synchronous RAM (one write port, one read port, registered read data, no reset on array).

## Test plan
- Write 0x11,0x22,0x33 back-to-back into empty buffer, `m_ready`=1 → `m_valid` at write+2, bytes out in order one per cycle, `fifo_cnd` 00→01→00.
- Write 256 bytes 0x00..0xFF with `m_ready`=0 → `fifo_cnd`=10 after 192nd write; drain → `m_last`=1 only on 0xFF; `fifo_cnd`=00 after final pop.
- Fill DEPTH=256, then 3 more writes → `fifo_cnd`=11, `drop_cnt`=3, stored data unchanged; `clr` → `fifo_cnd`=00, `drop_cnt`=0, `m_valid`=0.
- Stall `m_ready` low for 5 cycles while presenting 0xA5 → `m_data`=0xA5, `m_valid`=1 stable throughout.
- At `occ`=DEPTH assert `wr_en` and pop together → write dropped, `drop_cnt`=1, `occ`=DEPTH-1.
- Assert `rst` low mid-drain with 10 bytes queued → all outputs 0 immediately; after release, next write re-appears at write+2.

Source files
------------

// File: rtl/trivium_pkg.sv
// Shared definitions for the Trivium keystream core and its output buffer.
package trivium_pkg;

    // Buffer status returned to the core; the core resumes only on CND_EMPTY.
    typedef enum logic [1:0] {
        CND_EMPTY = 2'b00,
        CND_PART  = 2'b01,
        CND_HIGH  = 2'b10,
        CND_OVF   = 2'b11
    } fifo_cnd_t;

    // Output-side presentation states of the buffer.
    typedef enum logic [1:0] {
        OUT_EMPTY = 2'b00,
        OUT_FETCH = 2'b01,
        OUT_VALID = 2'b10
    } out_state_t;

    // Bytes per output batch; the core frames its stream in the same unit.
    localparam int TRIV_BURST = 256;

    // Status priority: a sticky overflow masks every occupancy indication.
    function automatic fifo_cnd_t cnd_encode(input logic ovf, input logic is_empty,
                                             input logic is_high);
        fifo_cnd_t cnd;
        if (ovf)
            cnd = CND_OVF;
        else if (is_empty)
            cnd = CND_EMPTY;
        else if (is_high)
            cnd = CND_HIGH;
        else
            cnd = CND_PART;
        return cnd;
    endfunction

endpackage

// File: rtl/trivium_buf_ram.sv
// Simple dual-port byte RAM: one write port, one read port, registered read.
// The array carries no reset so it maps onto block RAM.
module trivium_buf_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Read port, read every cycle; a same-address write returns the old contents.
    always_ff @(posedge clk) begin
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/trivium_out_buffer.sv
// Ciphertext output buffer behind the Trivium core: captures bytes on the
// core's write strobe, queues them in RAM plus one output register, and
// presents them over valid/ready with a batch-end marker. The RAM is read
// every cycle at the next head address so a pop can reload the output
// register back-to-back; a one-byte bypass covers the case where the head
// was written on the same edge it was read.
module trivium_out_buffer
    import trivium_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int HIWATER = 192,
    parameter int BURST   = TRIV_BURST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic [1:0]  fifo_cnd,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [15:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int BW = $clog2(BURST);
    localparam logic [OW-1:0] OCC_FULL  = OW'(DEPTH);
    localparam logic [OW-1:0] OCC_HIGH  = OW'(HIWATER);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BURST - 1);

    out_state_t    state_q, state_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;
    fifo_cnd_t     cnd_q, cnd_d;
    logic [7:0]    byp_q, byp_d;
    logic          byp_sel_q, byp_sel_d;

    logic          full;
    logic          wr_acc;
    logic          wr_drop;
    logic          pop;
    logic [OW-1:0] ram_cnt;
    logic          ram_nonempty;
    logic [7:0]    ram_rdata;
    logic [7:0]    head_data;

    // Full is judged on occupancy before any same-cycle pop.
    assign full         = (occ_q == OCC_FULL);
    assign wr_acc       = wr_en && !clr && !full;
    assign wr_drop      = wr_en && !clr && full;
    assign pop          = m_valid_q && m_ready && !clr;
    assign ram_cnt      = occ_q - OW'(state_q == OUT_VALID);
    assign ram_nonempty = (ram_cnt != '0);
    assign head_data    = byp_sel_q ? byp_q : ram_rdata;

    trivium_buf_ram #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_d),
        .rdata (ram_rdata)
    );

    // Output FSM: next state, read pointer, output register and batch position.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        bcnt_d    = bcnt_q;
        if (clr) begin
            state_d   = OUT_EMPTY;
            rd_ptr_d  = '0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            bcnt_d    = '0;
        end else begin
            case (state_q)
                OUT_EMPTY: begin
                    if (ram_nonempty)
                        state_d = OUT_FETCH;
                end
                OUT_FETCH: begin
                    m_data_d  = head_data;
                    m_valid_d = 1'b1;
                    m_last_d  = (bcnt_q == BCNT_LAST);
                    rd_ptr_d  = rd_ptr_q + AW'(1);
                    state_d   = OUT_VALID;
                end
                OUT_VALID: begin
                    if (pop) begin
                        bcnt_d = (bcnt_q == BCNT_LAST) ? '0 : bcnt_q + BW'(1);
                        if (ram_nonempty) begin
                            m_data_d = head_data;
                            m_last_d = (bcnt_d == BCNT_LAST);
                            rd_ptr_d = rd_ptr_q + AW'(1);
                        end else begin
                            state_d   = OUT_EMPTY;
                            m_valid_d = 1'b0;
                            m_last_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d   = OUT_EMPTY;
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end
            endcase
        end
    end

    // Write side, occupancy, overflow/drop bookkeeping and status encoding.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        occ_d     = occ_q;
        ovf_d     = ovf_q;
        drop_d    = drop_q;
        byp_d     = byp_q;
        byp_sel_d = 1'b0;
        if (clr) begin
            wr_ptr_d = '0;
            occ_d    = '0;
            ovf_d    = 1'b0;
            drop_d   = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d  = wr_ptr_q + AW'(1);
                byp_d     = wr_data;
                byp_sel_d = (wr_ptr_q == rd_ptr_d);
            end
            if (wr_acc && !pop)
                occ_d = occ_q + OW'(1);
            else if (!wr_acc && pop)
                occ_d = occ_q - OW'(1);
            if (wr_drop) begin
                ovf_d = 1'b1;
                if (drop_q != 16'hFFFF)
                    drop_d = drop_q + 16'd1;
            end
        end
        cnd_d = cnd_encode(ovf_d, occ_d == '0, occ_d >= OCC_HIGH);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= OUT_EMPTY;
            occ_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            bcnt_q    <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
            cnd_q     <= CND_EMPTY;
            byp_q     <= '0;
            byp_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            occ_q     <= occ_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            bcnt_q    <= bcnt_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
            cnd_q     <= cnd_d;
            byp_q     <= byp_d;
            byp_sel_q <= byp_sel_d;
        end
    end

    assign fifo_cnd = cnd_q;
    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign drop_cnt = drop_q;

endmodule
